// File: rtl/alineador_serial.sv
`default_nettype none
// ============================================================================
// Module      : alineador_serial
// Description : Receive-side deserializer and 10-bit symbol aligner. Shifts
//               in the serial line, hunts for the K28.5 comma to find the
//               symbol boundary, confirms it over several aligned commas,
//               then delivers one aligned symbol every ten bit-clocks.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   COMMA_LOCK  aligned commas needed to declare lock (1..7)
//   LOSS_LIMIT  off-boundary commas while locked that drop lock (1..7)
// Build option:
//   COMMA_RDPOS_EN  when defined, the RD+ form of K28.5 (1100000101) is also
//                   recognised as a comma; otherwise only RD- (0011111010).
// Ports:
//   clk       in   serial bit clock, rising edge
//   rst       in   asynchronous reset, active low
//   enb       in   clock enable; low freezes state, valid/commaDet read 0
//   serialIn  in   serial line, symbol bit 9 first
//   dataOut   out  last aligned symbol, bit 9 = first received
//   valid     out  one-cycle strobe, dataOut holds a new symbol
//   locked    out  high while aligned
//   commaDet  out  one-cycle strobe, comma seen at any bit position
// ============================================================================
module alineador_serial #(
  parameter int COMMA_LOCK = 3,
  parameter int LOSS_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       serialIn,
  output logic [9:0] dataOut,
  output logic       valid,
  output logic       locked,
  output logic       commaDet
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter range checks
  // --------------------------------------------------------------------------
  if ((COMMA_LOCK < 1) || (COMMA_LOCK > 7)) begin : g_bad_comma_lock
    $error("alineador_serial: COMMA_LOCK must be in 1..7");
  end
  if ((LOSS_LIMIT < 1) || (LOSS_LIMIT > 7)) begin : g_bad_loss_limit
    $error("alineador_serial: LOSS_LIMIT must be in 1..7");
  end

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [9:0] c_K28_5_RDN = 10'b0011111010;
`ifdef COMMA_RDPOS_EN
  localparam logic [9:0] c_K28_5_RDP = 10'b1100000101;
`endif
  localparam logic [3:0] c_BIT_LAST  = 4'd9;
  localparam logic [3:0] c_LOCK_CNT  = 4'(COMMA_LOCK);
  localparam logic [3:0] c_LOSS_CNT  = 4'(LOSS_LIMIT);

  localparam logic [1:0] c_BUSCAR    = 2'd0;
  localparam logic [1:0] c_CONFIRMAR = 2'd1;
  localparam logic [1:0] c_ALINEADO  = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Only the nine newest bits are kept: the window always re-reads them and
  // appends the incoming bit, so the oldest bit would never be looked at.
  logic [8:0] r_shift_reg;
  logic [3:0] r_bit_cnt;
  logic [2:0] r_cnt_comma;
  logic [2:0] r_cnt_err;
  logic [1:0] r_state;
  logic [9:0] r_data_out;
  logic       r_valid;
  logic       r_locked;
  logic       r_comma_det;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic [9:0] w_window;
  logic       w_comma;
  logic       w_boundary;
  logic [3:0] w_comma_inc;
  logic [3:0] w_err_inc;
  logic [1:0] w_state_nxt;
  logic [3:0] w_bit_cnt_nxt;
  logic [2:0] w_cnt_comma_nxt;
  logic [2:0] w_cnt_err_nxt;
  logic       w_load_sym;

  assign w_window = {r_shift_reg, serialIn};

`ifdef COMMA_RDPOS_EN
  assign w_comma = (w_window == c_K28_5_RDN) || (w_window == c_K28_5_RDP);
`else
  assign w_comma = (w_window == c_K28_5_RDN);
`endif

  // The window completes a symbol when this edge samples its tenth bit.
  assign w_boundary  = (r_bit_cnt == c_BIT_LAST);
  assign w_comma_inc = {1'b0, r_cnt_comma} + 4'd1;
  assign w_err_inc   = {1'b0, r_cnt_err} + 4'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = w_boundary ? 4'd0 : (r_bit_cnt + 4'd1);
    w_cnt_comma_nxt = r_cnt_comma;
    w_cnt_err_nxt   = r_cnt_err;
    w_load_sym      = 1'b0;

    case (r_state)
      c_BUSCAR: begin
        if (w_comma) begin
          // Anchor: the next bit is bit 9 of the following symbol.
          w_bit_cnt_nxt   = 4'd0;
          w_cnt_comma_nxt = 3'd1;
          if (c_LOCK_CNT == 4'd1) begin
            w_state_nxt   = c_ALINEADO;
            w_cnt_err_nxt = 3'd0;
          end else begin
            w_state_nxt   = c_CONFIRMAR;
          end
        end
      end

      c_CONFIRMAR: begin
        if (w_comma) begin
          if (w_boundary) begin
            w_cnt_comma_nxt = w_comma_inc[2:0];
            if (w_comma_inc == c_LOCK_CNT) begin
              // Lock is declared here, but this symbol is not delivered;
              // the first valid comes on the following boundary.
              w_state_nxt   = c_ALINEADO;
              w_cnt_err_nxt = 3'd0;
            end
          end else begin
            // Comma at a different phase: trust the newest one and restart.
            w_bit_cnt_nxt   = 4'd0;
            w_cnt_comma_nxt = 3'd1;
          end
        end
      end

      c_ALINEADO: begin
        // Every boundary symbol, commas included, goes to the decoder.
        w_load_sym = w_boundary;
        if (w_comma) begin
          if (w_boundary) begin
            w_cnt_err_nxt = 3'd0;
          end else begin
            w_cnt_err_nxt = w_err_inc[2:0];
            if (w_err_inc == c_LOSS_CNT) begin
              // Drop lock without re-anchoring; the hunt starts on the
              // next comma seen from BUSCAR.
              w_state_nxt     = c_BUSCAR;
              w_cnt_comma_nxt = 3'd0;
            end
          end
        end
      end

      default: begin
        w_state_nxt = c_BUSCAR;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift_reg <= 9'd0;
      r_bit_cnt   <= 4'd0;
      r_cnt_comma <= 3'd0;
      r_cnt_err   <= 3'd0;
      r_state     <= c_BUSCAR;
      r_data_out  <= 10'd0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_comma_det <= 1'b0;
    end else if (!enb) begin
      // Frozen: strobes are cleared so nothing is reported twice, and a
      // symbol interrupted here resumes seamlessly when enb returns.
      r_valid     <= 1'b0;
      r_comma_det <= 1'b0;
    end else begin
      r_shift_reg <= w_window[8:0];
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_cnt_comma <= w_cnt_comma_nxt;
      r_cnt_err   <= w_cnt_err_nxt;
      r_state     <= w_state_nxt;
      r_valid     <= w_load_sym;
      if (w_load_sym) begin
        r_data_out <= w_window;
      end
      r_comma_det <= w_comma;
      r_locked    <= (w_state_nxt == c_ALINEADO);
    end
  end

  assign dataOut  = r_data_out;
  assign valid    = r_valid;
  assign locked   = r_locked;
  assign commaDet = r_comma_det;

endmodule
`default_nettype wire

// File: tb/tb_alineador_serial.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module      : tb_alineador_serial
// Description : Self-checking bench for alineador_serial: a table of
//               symbol-level vectors, hand-written enable-gap, reset and
//               RD+ sequences, then a randomized stream compared cycle by
//               cycle against a symbol-phase reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alineador_serial;

  localparam int         COMMA_LOCK = 3;
  localparam int         LOSS_LIMIT = 4;
  localparam logic [9:0] K_RDN      = 10'b0011111010;
  localparam logic [9:0] K_RDP      = 10'b1100000101;
  localparam logic [9:0] D215       = 10'b1010101010;
`ifdef COMMA_RDPOS_EN
  localparam bit         RDPOS      = 1'b1;
`else
  localparam bit         RDPOS      = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       serialIn;
  logic [9:0] dataOut;
  logic       valid;
  logic       locked;
  logic       commaDet;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  alineador_serial #(
    .COMMA_LOCK(COMMA_LOCK),
    .LOSS_LIMIT(LOSS_LIMIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .serialIn (serialIn),
    .dataOut  (dataOut),
    .valid    (valid),
    .locked   (locked),
    .commaDet (commaDet)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One bit-clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic apply_bit(input logic b, input logic e);
    @(negedge clk);
    serialIn = b;
    enb      = e;
    @(posedge clk);
    #1;
    if (valid === 1'b1) vcount++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    enb = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Reference model: tracks the alignment phase as the enabled-edge index of
  // the last anchor; a boundary is any edge a multiple of ten after it.
  // --------------------------------------------------------------------------
  int         m_mode;    // 0 hunting, 1 confirming, 2 aligned
  int         m_k;
  int         m_anchor;
  int         m_hits;
  int         m_miss;
  int         m_hist;
  logic [9:0] m_data;
  logic       m_valid;
  logic       m_comma;

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_anchor = -1; m_hits = 0; m_miss = 0;
    m_hist = 0; m_data = 10'd0; m_valid = 1'b0; m_comma = 1'b0;
  endtask

  task automatic model_edge(input logic b, input logic e);
    int  w;
    bit  is_k;
    bit  bnd;
    if (!e) begin
      m_valid = 1'b0;
      m_comma = 1'b0;
      return;
    end
    w    = (m_hist * 2 + int'(b)) % 1024;
    is_k = (w == int'(K_RDN)) || (RDPOS && (w == int'(K_RDP)));
    bnd  = ((m_k - m_anchor) % 10) == 0;
    m_comma = is_k;
    m_valid = 1'b0;
    if (m_mode == 0) begin
      if (is_k) begin
        m_anchor = m_k;
        m_hits   = 1;
        if (m_hits >= COMMA_LOCK) begin m_mode = 2; m_miss = 0; end
        else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (is_k) begin
        if (bnd) begin
          m_hits++;
          if (m_hits == COMMA_LOCK) begin m_mode = 2; m_miss = 0; end
        end else begin
          m_anchor = m_k;
          m_hits   = 1;
        end
      end
    end else begin
      if (bnd) begin
        m_data  = 10'(w);
        m_valid = 1'b1;
      end
      if (is_k) begin
        if (bnd) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss == LOSS_LIMIT) m_mode = 0;
        end
      end
    end
    m_hist = w;
    m_k++;
  endtask

  // --------------------------------------------------------------------------
  // Symbol-level vector table
  // --------------------------------------------------------------------------
  typedef struct {
    int          pre_n;
    logic [31:0] pre_bits;
    logic [9:0]  sym;
    logic        exp_comma;
    logic        exp_locked;
    logic        exp_valid;
    logic [9:0]  exp_data;
    int          exp_vcount;
  } vec_t;

  vec_t tbl[17];

  initial begin
    rst = 1'b0; enb = 1'b0; serialIn = 1'b0;

    tbl[0]  = '{17, 32'h1A5B3, K_RDN, 1'b1, 1'b0, 1'b0, 10'h000, 0};
    tbl[1]  = '{0,  32'h0,     D215,  1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[2]  = '{0,  32'h0,     K_RDN, 1'b1, 1'b0, 1'b0, 10'h000, 0};
    tbl[3]  = '{0,  32'h0,     D215,  1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[4]  = '{0,  32'h0,     K_RDN, 1'b1, 1'b1, 1'b0, 10'h000, 0};
    tbl[5]  = '{0,  32'h0,     D215,  1'b0, 1'b1, 1'b1, 10'h2AA, 1};
    tbl[6]  = '{0,  32'h0,     K_RDN, 1'b1, 1'b1, 1'b1, 10'h0FA, 1};
    tbl[7]  = '{3,  32'h0,     K_RDN, 1'b1, 1'b1, 1'b0, 10'h000, 1};
    tbl[8]  = '{3,  32'h0,     K_RDN, 1'b1, 1'b1, 1'b0, 10'h000, 1};
    tbl[9]  = '{3,  32'h0,     K_RDN, 1'b1, 1'b1, 1'b0, 10'h000, 1};
    tbl[10] = '{3,  32'h0,     K_RDN, 1'b1, 1'b0, 1'b0, 10'h000, 2};
    tbl[11] = '{0,  32'h0,     D215,  1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[12] = '{0,  32'h0,     D215,  1'b0, 1'b0, 1'b0, 10'h000, 0};
    tbl[13] = '{0,  32'h0,     K_RDN, 1'b1, 1'b0, 1'b0, 10'h000, 0};
    tbl[14] = '{1,  32'h0,     K_RDN, 1'b1, 1'b0, 1'b0, 10'h000, 0};
    tbl[15] = '{0,  32'h0,     K_RDN, 1'b1, 1'b0, 1'b0, 10'h000, 0};
    tbl[16] = '{0,  32'h0,     K_RDN, 1'b1, 1'b1, 1'b0, 10'h000, 0};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("reset dataOut", 32'(dataOut), 32'h0);
    check("reset valid", 32'(valid), 32'h0);
    check("reset locked", 32'(locked), 32'h0);
    check("reset commaDet", 32'(commaDet), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- table: lock, delivery, loss, re-anchor ----------------
    for (int i = 0; i < 17; i++) begin
      vcount = 0;
      for (int j = tbl[i].pre_n - 1; j >= 0; j--) apply_bit(tbl[i].pre_bits[j], 1'b1);
      for (int j = 9; j >= 0; j--) apply_bit(tbl[i].sym[j], 1'b1);
      check($sformatf("vec%0d commaDet", i), 32'(commaDet), 32'(tbl[i].exp_comma));
      check($sformatf("vec%0d locked", i), 32'(locked), 32'(tbl[i].exp_locked));
      check($sformatf("vec%0d valid", i), 32'(valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check($sformatf("vec%0d dataOut", i), 32'(dataOut), 32'(tbl[i].exp_data));
      check($sformatf("vec%0d valid pulses", i), 32'(vcount), 32'(tbl[i].exp_vcount));
    end

    // ---------------- enb gap inside a locked symbol ----------------
    begin : enb_gap
      logic [14:0] en_pat;
      logic [9:0]  sym;
      int          k;
      int          first_v;
      en_pat  = 15'b111100000111111;
      sym     = D215;
      k       = 9;
      first_v = 0;
      vcount  = 0;
      for (int c = 14; c >= 0; c--) begin
        if (en_pat[c]) begin
          apply_bit(sym[k], 1'b1);
          k--;
        end else begin
          apply_bit(1'($urandom_range(0, 1)), 1'b0);
          check("gap valid", 32'(valid), 32'h0);
          check("gap commaDet", 32'(commaDet), 32'h0);
        end
        if (valid === 1'b1 && first_v == 0) first_v = 15 - c;
      end
      check("gap valid cycle", 32'(first_v), 32'd15);
      check("gap valid pulses", 32'(vcount), 32'd1);
      check("gap dataOut", 32'(dataOut), 32'h2AA);
      check("gap locked", 32'(locked), 32'h1);
    end

    // ---------------- asynchronous reset mid-symbol ----------------
    begin : mid_reset
      logic [9:0] sym;
      sym = D215;
      for (int j = 9; j >= 6; j--) apply_bit(sym[j], 1'b1);
      check("prereset locked", 32'(locked), 32'h1);
      check("prereset dataOut", 32'(dataOut), 32'h2AA);
      #2;
      rst = 1'b0;
      #0.5;
      check("async reset dataOut", 32'(dataOut), 32'h0);
      check("async reset locked", 32'(locked), 32'h0);
      check("async reset valid", 32'(valid), 32'h0);
      check("async reset commaDet", 32'(commaDet), 32'h0);
      #0.5;
      rst = 1'b1;
      sym = K_RDN;
      for (int j = 9; j >= 0; j--) apply_bit(sym[j], 1'b1);
      check("postreset commaDet", 32'(commaDet), 32'h1);
      check("postreset locked", 32'(locked), 32'h0);
    end

    // ---------------- RD+ comma: build-dependent ----------------
    begin : rdpos
      logic [9:0] sym;
      int         ncomma;
      do_reset();
      sym    = K_RDP;
      ncomma = 0;
      for (int s = 0; s < 4; s++) begin
        for (int j = 9; j >= 0; j--) begin
          apply_bit(sym[j], 1'b1);
          if (commaDet === 1'b1) ncomma++;
        end
        check($sformatf("rdpos sym%0d locked", s), 32'(locked), 32'(RDPOS && (s >= 2)));
      end
      check("rdpos comma count", 32'(ncomma), RDPOS ? 32'd4 : 32'd0);
    end

    // ---------------- randomized stream vs reference model ----------------
    begin : rand_run
      bit         q[$];
      logic [9:0] s;
      logic       b;
      logic       e;
      int         r;
      int         nlock;
      do_reset();
      model_reset();
      nlock = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        if (q.size() == 0) begin
          r = int'($urandom_range(0, 9));
          if (r <= 3) begin
            s = K_RDN;
            for (int j = 9; j >= 0; j--) q.push_back(s[j]);
          end else if (r == 4) begin
            s = K_RDP;
            for (int j = 9; j >= 0; j--) q.push_back(s[j]);
          end else if (r <= 7) begin
            s = 10'($urandom_range(0, 1023));
            for (int j = 9; j >= 0; j--) q.push_back(s[j]);
          end else begin
            for (int j = int'($urandom_range(1, 9)); j > 0; j--) q.push_back(1'($urandom_range(0, 1)));
          end
        end
        e = ($urandom_range(0, 9) != 0);
        b = e ? q.pop_front() : 1'($urandom_range(0, 1));
        apply_bit(b, e);
        model_edge(b, e);
        if (m_mode == 2) nlock++;
        check($sformatf("rand cyc%0d {dataOut,valid,locked,commaDet}", cyc),
              32'({dataOut, valid, locked, commaDet}),
              32'({m_data, m_valid, (m_mode == 2), m_comma}));
      end
      if (nlock == 0) begin
        checks++;
        errors++;
        $display("FAIL rand coverage: locked cycles 0, required > 0");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
